// File: rtl/game_timer_pkg.sv
// Shared constants and BCD helpers for the game countdown timer.
package game_timer_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_PAUSE   = 2'd2;
   localparam logic [1:0] ST_EXPIRED = 2'd3;

   localparam logic [3:0] BCD_MAX_DIGIT    = 4'd9;
   localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;
   localparam logic [7:0] BCD_MAX_SEC      = 8'h59;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
      return (d > lim) ? lim : d;
   endfunction

   // One-second BCD decrement of {min, sec}; caller guarantees the time is non-zero.
   function automatic logic [15:0] bcd_dec(input logic [7:0] mn, input logic [7:0] sc);
      logic [7:0] m;
      logic [7:0] s;
      m = mn;
      s = sc;
      if (s[3:0] != 4'd0) begin
         s[3:0] = s[3:0] - 4'd1;
      end else if (s[7:4] != 4'd0) begin
         s[7:4] = s[7:4] - 4'd1;
         s[3:0] = BCD_MAX_DIGIT;
      end else begin
         s = BCD_MAX_SEC;
         if (m[3:0] != 4'd0) begin
            m[3:0] = m[3:0] - 4'd1;
         end else begin
            m[7:4] = m[7:4] - 4'd1;
            m[3:0] = BCD_MAX_DIGIT;
         end
      end
      return {m, s};
   endfunction

endpackage

// File: rtl/game_timer_prescaler.sv
// Clock prescaler: counts 0..DIV-1 while enabled, flags the terminal count.
module prescaler #(
   parameter int unsigned DIV = 2
) (
   input  logic CLK_50MHZ,
   input  logic RST,
   input  logic en,
   input  logic clr,
   output logic tc
);

   localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign tc = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tc ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK_50MHZ or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/game_timer.sv
// Loadable MM:SS BCD countdown timer with start/stop control and expiry strobe.
module game_timer
   import game_timer_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 50000000,
   parameter int unsigned TICK_HZ = 1
) (
   input  logic       CLK_50MHZ,
   input  logic       RST,
   input  logic       load,
   input  logic [7:0] load_min,
   input  logic [7:0] load_sec,
   input  logic       start,
   input  logic       stop,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       running,
   output logic       expired,
   output logic       expire_pulse,
   output logic       tick
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;

   logic [1:0]  state_q, state_d;
   logic [7:0]  min_q, min_d;
   logic [7:0]  sec_q, sec_d;
   logic        tick_q, tick_d;
   logic        pulse_q, pulse_d;
   logic        running_q, expired_q;
   logic        tc;
   logic        time_zero;
   logic [15:0] dec;

   prescaler #(.DIV(DIV)) u_prescaler (
      .CLK_50MHZ (CLK_50MHZ),
      .RST       (RST),
      .en        (state_q == ST_RUN),
      .clr       (load),
      .tc        (tc)
   );

   assign time_zero = (min_q == 8'h00) && (sec_q == 8'h00);
   assign dec       = bcd_dec(min_q, sec_q);

   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sec_d   = sec_q;
      tick_d  = 1'b0;
      pulse_d = 1'b0;
      if (load) begin
         state_d = ST_IDLE;
         min_d   = {clamp_digit(load_min[7:4], BCD_MAX_DIGIT), clamp_digit(load_min[3:0], BCD_MAX_DIGIT)};
         sec_d   = {clamp_digit(load_sec[7:4], BCD_MAX_SEC_TENS), clamp_digit(load_sec[3:0], BCD_MAX_DIGIT)};
      end else begin
         case (state_q)
            ST_IDLE, ST_PAUSE: begin
               if (start && !stop && !time_zero) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               // A stop on the terminal-count edge still takes that second off.
               if (tc) begin
                  tick_d = 1'b1;
                  min_d  = dec[15:8];
                  sec_d  = dec[7:0];
                  if (dec == 16'h0000) begin
                     state_d = ST_EXPIRED;
                     pulse_d = 1'b1;
                  end else if (stop) begin
                     state_d = ST_PAUSE;
                  end
               end else if (stop) begin
                  state_d = ST_PAUSE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK_50MHZ or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         min_q     <= '0;
         sec_q     <= '0;
         tick_q    <= 1'b0;
         pulse_q   <= 1'b0;
         running_q <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         tick_q    <= tick_d;
         pulse_q   <= pulse_d;
         running_q <= (state_d == ST_RUN);
         expired_q <= (state_d == ST_EXPIRED);
      end
   end

   assign min_bcd      = min_q;
   assign sec_bcd      = sec_q;
   assign running      = running_q;
   assign expired      = expired_q;
   assign expire_pulse = pulse_q;
   assign tick         = tick_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer at 10 clocks per second.
module tb_game_timer;

   logic       clk;
   logic       rst;
   logic       load;
   logic [7:0] load_min;
   logic [7:0] load_sec;
   logic       start;
   logic       stop;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic       running;
   logic       expired;
   logic       expire_pulse;
   logic       tick;

   int checks = 0;
   int errors = 0;

   game_timer #(.CLK_HZ(10), .TICK_HZ(1)) dut (
      .CLK_50MHZ    (clk),
      .RST          (rst),
      .load         (load),
      .load_min     (load_min),
      .load_sec     (load_sec),
      .start        (start),
      .stop         (stop),
      .min_bcd      (min_bcd),
      .sec_bcd      (sec_bcd),
      .running      (running),
      .expired      (expired),
      .expire_pulse (expire_pulse),
      .tick         (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       ld;
      logic [7:0] lm;
      logic [7:0] ls;
      logic       st;
      logic       sp;
      logic [7:0] emin;
      logic [7:0] esec;
      logic       erun;
   } vec_t;

   vec_t vecs[14];

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Drive one cycle of strobes, then sample 1 time unit after the edge.
   task automatic cyc(input logic l, input logic [7:0] lm, input logic [7:0] ls,
                      input logic st, input logic sp);
      load = l; load_min = lm; load_sec = ls; start = st; stop = sp;
      @(posedge clk);
      #1;
      load = 1'b0; start = 1'b0; stop = 1'b0;
   endtask

   task automatic idle();
      cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; load_min = '0; load_sec = '0; start = 1'b0; stop = 1'b0;

      //               ld    lm     ls     st    sp    emin   esec   erun
      vecs[0]  = '{1'b1, 8'hAB, 8'h7C, 1'b0, 1'b0, 8'h99, 8'h59, 1'b0};
      vecs[1]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h99, 8'h59, 1'b0};
      vecs[2]  = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[3]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[4]  = '{1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0};
      vecs[5]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h12, 8'h34, 1'b1};
      vecs[6]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h12, 8'h34, 1'b1};
      vecs[7]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h12, 8'h34, 1'b0};
      vecs[8]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h12, 8'h34, 1'b0};
      vecs[9]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h12, 8'h34, 1'b0};
      vecs[10] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h12, 8'h34, 1'b1};
      vecs[11] = '{1'b1, 8'h9F, 8'h6A, 1'b0, 1'b0, 8'h99, 8'h59, 1'b0};
      vecs[12] = '{1'b1, 8'h05, 8'h47, 1'b1, 1'b0, 8'h05, 8'h47, 1'b0};
      vecs[13] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h05, 8'h47, 1'b0};

      #2;
      check8("reset_min", min_bcd, 8'h00);
      check8("reset_sec", sec_bcd, 8'h00);
      check1("reset_running", running, 1'b0);
      check1("reset_expired", expired, 1'b0);
      check1("reset_pulse", expire_pulse, 1'b0);
      check1("reset_tick", tick, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int unsigned i = 0; i < 14; i++) begin
         cyc(vecs[i].ld, vecs[i].lm, vecs[i].ls, vecs[i].st, vecs[i].sp);
         check8($sformatf("vec%0d_min", i), min_bcd, vecs[i].emin);
         check8($sformatf("vec%0d_sec", i), sec_bcd, vecs[i].esec);
         check1($sformatf("vec%0d_running", i), running, vecs[i].erun);
         check1($sformatf("vec%0d_expired", i), expired, 1'b0);
         check1($sformatf("vec%0d_tick", i), tick, 1'b0);
         check1($sformatf("vec%0d_pulse", i), expire_pulse, 1'b0);
      end

      // 00:03 countdown to expiry
      cyc(1'b1, 8'h00, 8'h03, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      check1("cd_start_running", running, 1'b1);
      for (int unsigned c = 1; c <= 34; c++) begin
         idle();
         check1($sformatf("cd%0d_tick", c), tick, (c % 10 == 0) && (c <= 30));
         check1($sformatf("cd%0d_pulse", c), expire_pulse, c == 30);
         check8($sformatf("cd%0d_sec", c), sec_bcd, (c >= 30) ? 8'h00 : 8'(3 - c / 10));
         check1($sformatf("cd%0d_running", c), running, c < 30);
         check1($sformatf("cd%0d_expired", c), expired, c >= 30);
      end
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      check1("exp_start_ignored", expired, 1'b1);
      check1("exp_start_not_running", running, 1'b0);
      cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      check1("exp_stop_ignored", expired, 1'b1);
      cyc(1'b1, 8'h01, 8'h00, 1'b0, 1'b0);
      check1("exp_load_clears", expired, 1'b0);
      check8("exp_load_min", min_bcd, 8'h01);
      check8("exp_load_sec", sec_bcd, 8'h00);

      // 10:00 minute borrow
      cyc(1'b1, 8'h10, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      for (int unsigned c = 1; c <= 9; c++) idle();
      check8("borrow_c9_min", min_bcd, 8'h10);
      idle();
      check8("borrow_min", min_bcd, 8'h09);
      check8("borrow_sec", sec_bcd, 8'h59);
      check1("borrow_tick", tick, 1'b1);

      // pause holds time and prescaler phase
      cyc(1'b1, 8'h00, 8'h05, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      for (int unsigned c = 1; c <= 13; c++) idle();
      cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      check1("pause_running", running, 1'b0);
      check8("pause_sec", sec_bcd, 8'h04);
      for (int unsigned c = 15; c <= 39; c++) idle();
      check8("pause_hold_sec", sec_bcd, 8'h04);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      check1("resume_running", running, 1'b1);
      for (int unsigned c = 41; c <= 45; c++) idle();
      check8("resume_c45_sec", sec_bcd, 8'h04);
      check1("resume_c45_tick", tick, 1'b0);
      idle();
      check8("resume_c46_sec", sec_bcd, 8'h03);
      check1("resume_c46_tick", tick, 1'b1);

      // stop coincident with terminal count
      cyc(1'b1, 8'h00, 8'h02, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      for (int unsigned c = 1; c <= 9; c++) idle();
      cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      check8("stop_tc_sec", sec_bcd, 8'h01);
      check1("stop_tc_tick", tick, 1'b1);
      check1("stop_tc_running", running, 1'b0);
      cyc(1'b1, 8'h00, 8'h01, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      for (int unsigned c = 1; c <= 9; c++) idle();
      cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      check8("stop_tc_exp_sec", sec_bcd, 8'h00);
      check1("stop_tc_exp_expired", expired, 1'b1);
      check1("stop_tc_exp_pulse", expire_pulse, 1'b1);
      idle();
      check1("stop_tc_exp_pulse_once", expire_pulse, 1'b0);

      // asynchronous reset mid-run
      cyc(1'b1, 8'h00, 8'h09, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      for (int unsigned c = 1; c <= 5; c++) idle();
      #3;
      rst = 1'b1;
      #1;
      check8("async_rst_sec", sec_bcd, 8'h00);
      check1("async_rst_running", running, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      check1("post_rst_zero_start", running, 1'b0);
      cyc(1'b1, 8'h00, 8'h07, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      check1("post_rst_running", running, 1'b1);
      check8("post_rst_sec", sec_bcd, 8'h07);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1, countdown step rate in Hz; CLK_HZ/TICK_HZ SHALL be an integer of at least 2.
REQ-003 Port CLK_50MHZ  input  1  sole clock, rising edge.
REQ-004 Port RST  input  1  reset, asynchronous, active-high.
REQ-005 Port load  input  1  one-cycle strobe; captures load_min/load_sec.
REQ-006 Port load_min  input  8  BCD minutes {tens, units}, range 00-99.
REQ-007 Port load_sec  input  8  BCD seconds {tens, units}, range 00-59.
REQ-008 Port start  input  1  one-cycle strobe; begin or resume the countdown.
REQ-009 Port stop  input  1  one-cycle strobe; pause the countdown.
REQ-010 Port min_bcd  output  8  current minutes, BCD, registered.
REQ-011 Port sec_bcd  output  8  current seconds, BCD, registered.
REQ-012 Port running  output  1  high while in RUN.
REQ-013 Port expired  output  1  level, high while in EXPIRED.
REQ-014 Port expire_pulse  output  1  single-cycle strobe on entry to EXPIRED.
REQ-015 Port tick  output  1  single-cycle strobe on each prescaler terminal count in RUN.

Function
REQ-016 FSM states: IDLE, RUN, PAUSE, EXPIRED.
REQ-017 Prescaler counts 0..CLK_HZ/TICK_HZ-1 only in RUN, holds in PAUSE, clears on load and on reset.
REQ-018 At prescaler terminal count in RUN: tick=1 and the time decrements by one second in the same edge.
REQ-019 Decrement rules: units 0 borrows from tens; sec 00 becomes 59 with minutes decremented (10:00 -> 09:59, 01:00 -> 00:59).
REQ-020 Decrement reaching 00:00: next state EXPIRED, expire_pulse=1 for exactly one cycle, running=0.
REQ-021 IDLE/PAUSE + start with time != 00:00 -> RUN; start with time 00:00 is ignored.
REQ-022 RUN + stop -> PAUSE; the time and the prescaler value are held.
REQ-023 load in any state -> IDLE with new time on the next edge; the prescaler clears.
REQ-024 Load clamping: any BCD digit >9 loads as 9; a seconds tens digit >5 loads as 5.
REQ-025 Simultaneous events: load beats start and stop; stop beats start; a stop coincident with a terminal count still applies that decrement.
REQ-026 EXPIRED is left only by load; start and stop are ignored there.
REQ-027 start in RUN and stop in IDLE/PAUSE/EXPIRED have no effect.
REQ-028 All outputs are driven from registers; latency from strobe to state or output change is one clock.

Reset
REQ-029 RST asserted asynchronously forces: state IDLE, min_bcd=8'h00, sec_bcd=8'h00, prescaler=0, running=0, expired=0, expire_pulse=0, tick=0.
REQ-030 Reset mid-countdown discards the time and pending strobes; operation resumes at the first edge after RST deasserts.

Structure
REQ-031 A shared package holds the FSM state encoding and the BCD limit constants (9, 5, 59).
REQ-032 Sub-module prescaler (parameter DIV, ports CLK_50MHZ, RST, en, clr, tc) generates the terminal count.
REQ-033 Sizes: prescaler width is clog2(CLK_HZ/TICK_HZ); no multipliers or dividers in the datapath.

Verification (CLK_HZ=10, TICK_HZ=1, so 10 cycles per second)
REQ-034 Load 00:03, start -> tick every 10 cycles; sec 03, 02, 01, 00; expire_pulse one cycle 30 cycles after start; expired=1; running=0.
REQ-035 Load 10:00, start -> after 10 cycles min_bcd=8'h09, sec_bcd=8'h59.
REQ-036 Load 00:05, start, stop at cycle 14, start at cycle 40 -> sec=04 while paused; next decrement 6 cycles after resume.
REQ-037 Load min=8'hAB, sec=8'h7C -> min_bcd=8'h99, sec_bcd=8'h59; start+stop in the same cycle -> state stays IDLE.
REQ-038 Load 00:00 then start -> remains IDLE, expire_pulse never asserts; in EXPIRED, a load of 01:00 -> IDLE, expired=0.
REQ-039 RST asserted mid-RUN, asynchronously between edges -> outputs go to 00:00, running=0 before the next edge.
